id_ex_stage: RTL and testbench

- ID/EX pipeline register and ALU-control decoder; sits directly upstream of the 32-bit ALU.
- Takes decoded instruction fields and register-file read data from decode.
- Drives registered operands and the 3-bit ALU control code into execute.
- Detects load-use hazards, stalls decode, inserts bubbles, and honours flush (taken branch/jump) and downstream hold.

---
 rtl/id_ex_stage.sv | 213 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and load-use hazard detection.
// Feeds registered operands, control code and memory/write-back enables to execute.
module id_ex_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [4:0]            id_shamt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [WIDTH-1:0]      id_rs_data,
  input  logic [WIDTH-1:0]      id_rt_data,
  input  logic [15:0]           id_imm,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic [WIDTH-1:0]      ex_op1,
  output logic [WIDTH-1:0]      ex_op2,
  output logic [2:0]            ex_alu_control,
  output logic [WIDTH-1:0]      ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_NOP = 3'b111;

  logic [WIDTH-1:0]      w_imm_sext;
  logic [WIDTH-1:0]      w_imm_zext;
  logic [WIDTH-1:0]      w_shamt_zext;
  logic [2:0]            w_code;
  logic [WIDTH-1:0]      w_op1;
  logic [WIDTH-1:0]      w_op2;
  logic [WIDTH-1:0]      w_store;
  logic [REG_ADDR_W-1:0] w_dest;
  logic                  w_rw;
  logic                  w_wr_en;
  logic                  w_mr;
  logic                  w_mw;
  logic                  w_br;
  logic                  w_reads_rt;
  logic                  w_hazard;

  logic                  r_valid;
  logic [WIDTH-1:0]      r_op1;
  logic [WIDTH-1:0]      r_op2;
  logic [2:0]            r_code;
  logic [WIDTH-1:0]      r_store;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_branch;

  assign w_imm_sext   = {{(WIDTH-16){id_imm[15]}}, id_imm};
  assign w_imm_zext   = {{(WIDTH-16){1'b0}}, id_imm};
  assign w_shamt_zext = {{(WIDTH-5){1'b0}}, id_shamt};

  always_comb begin
    w_code     = ALU_NOP;
    w_op1      = '0;
    w_op2      = '0;
    w_store    = '0;
    w_dest     = '0;
    w_rw       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_br       = 1'b0;
    w_reads_rt = 1'b0;
    case (id_opcode)
      6'b000000: begin
        w_reads_rt = 1'b1;
        w_dest     = id_rd;
        w_op1      = id_rs_data;
        w_op2      = id_rt_data;
        w_rw       = 1'b1;
        case (id_funct)
          6'b100000: w_code = ALU_ADD;
          6'b100010: w_code = ALU_SUB;
          6'b100100: w_code = ALU_AND;
          6'b100101: w_code = ALU_OR;
          6'b100110: w_code = ALU_XOR;
          6'b100111: w_code = ALU_NOR;
          6'b000000: begin
            w_code = ALU_SHL;
            w_op1  = id_rt_data;
            w_op2  = w_shamt_zext;
          end
          default: begin
            w_code = ALU_NOP;
            w_rw   = 1'b0;
          end
        endcase
      end
      6'b001000: begin
        w_code = ALU_ADD;
        w_op1  = id_rs_data;
        w_op2  = w_imm_sext;
        w_dest = id_rt;
        w_rw   = 1'b1;
      end
      6'b001100: begin
        w_code = ALU_AND;
        w_op1  = id_rs_data;
        w_op2  = w_imm_zext;
        w_dest = id_rt;
        w_rw   = 1'b1;
      end
      6'b001101: begin
        w_code = ALU_OR;
        w_op1  = id_rs_data;
        w_op2  = w_imm_zext;
        w_dest = id_rt;
        w_rw   = 1'b1;
      end
      6'b100011: begin
        w_code = ALU_ADD;
        w_op1  = id_rs_data;
        w_op2  = w_imm_sext;
        w_dest = id_rt;
        w_mr   = 1'b1;
        w_rw   = 1'b1;
      end
      6'b101011: begin
        w_code     = ALU_ADD;
        w_op1      = id_rs_data;
        w_op2      = w_imm_sext;
        w_store    = id_rt_data;
        w_mw       = 1'b1;
        w_reads_rt = 1'b1;
      end
      6'b000100: begin
        w_code     = ALU_SUB;
        w_op1      = id_rs_data;
        w_op2      = id_rt_data;
        w_br       = 1'b1;
        w_reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // r0 is hardwired, so a write to it is dropped here rather than in write-back
  assign w_wr_en = w_rw & (|w_dest);

  assign w_hazard = id_valid & r_valid & r_mem_read & (|r_dest) &
                    ((r_dest == id_rs) | (w_reads_rt & (r_dest == id_rt)));
  assign stall_id = w_hazard & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_code      <= ALU_NOP;
      r_store     <= '0;
      r_dest      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (flush || (!hold && (stall_id || !id_valid))) begin
      r_valid     <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_code      <= ALU_NOP;
      r_store     <= '0;
      r_dest      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (!hold) begin
      r_valid     <= 1'b1;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_code      <= w_code;
      r_store     <= w_store;
      r_dest      <= w_dest;
      r_reg_write <= w_wr_en;
      r_mem_read  <= w_mr;
      r_mem_write <= w_mw;
      r_branch    <= w_br;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_op1         = r_op1;
  assign ex_op2         = r_op2;
  assign ex_alu_control = r_code;
  assign ex_store_data  = r_store;
  assign ex_dest        = r_dest;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_branch      = r_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic compared
// against an instruction-level model of the EX register contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        flush, hold;
  logic        stall_id, ex_valid;
  logic [31:0] ex_op1, ex_op2, ex_store_data;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .flush(flush), .hold(hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
  );

  typedef struct {
    logic        valid;
    logic [31:0] op1, op2, store;
    logic [2:0]  code;
    logic [4:0]  dest;
    logic        rw, mr, mw, br;
  } ex_t;

  ex_t exp_ex;
  int  n_pass = 0;
  int  n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b.valid = 0; b.op1 = 0; b.op2 = 0; b.store = 0; b.code = 3'b111;
    b.dest = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0;
    return b;
  endfunction

  // instruction-level meaning of the current ID inputs
  function automatic ex_t decode();
    ex_t e = bubble();
    logic [31:0] sx = {{16{id_imm[15]}}, id_imm};
    logic [31:0] zx = {16'h0, id_imm};
    e.valid = 1;
    case (id_opcode)
      6'd0: begin
        e.dest = id_rd; e.op1 = id_rs_data; e.op2 = id_rt_data; e.rw = 1;
        case (id_funct)
          6'h20: e.code = 3'd0;
          6'h22: e.code = 3'd1;
          6'h24: e.code = 3'd3;
          6'h25: e.code = 3'd4;
          6'h26: e.code = 3'd5;
          6'h27: e.code = 3'd6;
          6'h00: begin e.code = 3'd2; e.op1 = id_rt_data; e.op2 = 32'(id_shamt); end
          default: begin e.code = 3'd7; e.rw = 0; end
        endcase
      end
      6'h08: begin e.code = 3'd0; e.op1 = id_rs_data; e.op2 = sx; e.dest = id_rt; e.rw = 1; end
      6'h0C: begin e.code = 3'd3; e.op1 = id_rs_data; e.op2 = zx; e.dest = id_rt; e.rw = 1; end
      6'h0D: begin e.code = 3'd4; e.op1 = id_rs_data; e.op2 = zx; e.dest = id_rt; e.rw = 1; end
      6'h23: begin e.code = 3'd0; e.op1 = id_rs_data; e.op2 = sx; e.dest = id_rt; e.rw = 1; e.mr = 1; end
      6'h2B: begin e.code = 3'd0; e.op1 = id_rs_data; e.op2 = sx; e.store = id_rt_data; e.mw = 1; end
      6'h04: begin e.code = 3'd1; e.op1 = id_rs_data; e.op2 = id_rt_data; e.br = 1; end
      default: ;
    endcase
    if (e.dest == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic exp_stall();
    logic reads_rt = (id_opcode == 6'd0) || (id_opcode == 6'h2B) || (id_opcode == 6'h04);
    if (flush || !id_valid || !exp_ex.valid || !exp_ex.mr || exp_ex.dest == 0) return 0;
    return (exp_ex.dest == id_rs) || (reads_rt && exp_ex.dest == id_rt);
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(exp_ex.valid));
    chk({tag, ".op1"}, ex_op1, exp_ex.op1);
    chk({tag, ".op2"}, ex_op2, exp_ex.op2);
    chk({tag, ".code"}, 32'(ex_alu_control), 32'(exp_ex.code));
    chk({tag, ".store"}, ex_store_data, exp_ex.store);
    chk({tag, ".dest"}, 32'(ex_dest), 32'(exp_ex.dest));
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(exp_ex.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(exp_ex.mr));
    chk({tag, ".mw"}, 32'(ex_mem_write), 32'(exp_ex.mw));
    chk({tag, ".br"}, 32'(ex_branch), 32'(exp_ex.br));
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [15:0] imm, input logic fl, input logic hd);
    id_valid = v; id_opcode = op; id_funct = fn; id_shamt = sh;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; flush = fl; hold = hd;
  endtask

  // inputs are already driven; check stall, advance model, clock, check EX
  task automatic cycle(input string tag);
    logic st;
    #1;
    st = exp_stall();
    chk({tag, ".stall"}, 32'(stall_id), 32'(st));
    if (flush) exp_ex = bubble();
    else if (hold) exp_ex = exp_ex;
    else if (st || !id_valid) exp_ex = bubble();
    else exp_ex = decode();
    @(posedge clk);
    #1;
    check_ex(tag);
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
  logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h2A};

  initial begin
    reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ex = bubble();
    #23;
    check_ex("in_reset");
    chk("in_reset.stall", 32'(stall_id), 32'd0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    cycle("idle1");
    cycle("idle2");

    // SUB r4 = 10 - 3
    drive(1, 6'h00, 6'h22, 0, 1, 2, 4, 10, 3, 0, 0, 0); cycle("sub");
    chk("sub.op1_const", ex_op1, 32'd10);
    chk("sub.code_const", 32'(ex_alu_control), 32'd1);
    // ADDI with negative imm, ANDI with bit 15 set
    drive(1, 6'h08, 0, 0, 1, 7, 0, 5, 0, 16'hFFFE, 0, 0); cycle("addi");
    chk("addi.sext", ex_op2, 32'hFFFF_FFFE);
    drive(1, 6'h0C, 0, 0, 1, 7, 0, 5, 0, 16'h8000, 0, 0); cycle("andi");
    chk("andi.zext", ex_op2, 32'h0000_8000);
    // load-use: LW r8 then ADD rs=8 -> one bubble, then ADD
    drive(1, 6'h23, 0, 0, 1, 8, 0, 100, 0, 16'h4, 0, 0); cycle("lw1");
    drive(1, 6'h00, 6'h20, 0, 8, 2, 9, 11, 22, 0, 0, 0); cycle("use_stall");
    chk("use_stall.bubble", 32'(ex_valid), 32'd0);
    cycle("use_go");
    chk("use_go.code", 32'(ex_alu_control), 32'd0);
    // LW r8 then ADDI rt=8 (rt not read) -> no stall
    drive(1, 6'h23, 0, 0, 1, 8, 0, 100, 0, 16'h4, 0, 0); cycle("lw2");
    drive(1, 6'h08, 0, 0, 3, 8, 0, 7, 0, 16'h1, 0, 0); cycle("addi_nostall");
    // flush coincident with a load-use hazard
    drive(1, 6'h23, 0, 0, 1, 8, 0, 100, 0, 16'h4, 0, 0); cycle("lw3");
    drive(1, 6'h00, 6'h20, 0, 8, 2, 9, 11, 22, 0, 1, 0); cycle("flush_stall");
    // hold for three cycles with changing ID inputs
    drive(1, 6'h0D, 0, 0, 1, 5, 0, 32'h1234, 0, 16'h00F0, 0, 0); cycle("pre_hold");
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h00, 6'h26, 0, 5'(i), 3, 6, $urandom, $urandom, 16'(i), 0, 1);
      cycle("hold");
    end
    drive(1, 6'h00, 6'h27, 0, 1, 3, 6, 32'hF0, 32'h0F, 0, 0, 0); cycle("hold_release");
    // SLL and rd=0
    drive(1, 6'h00, 6'h00, 4, 0, 1, 5, 0, 1, 0, 0, 0); cycle("sll");
    chk("sll.op2_const", ex_op2, 32'd4);
    drive(1, 6'h00, 6'h20, 0, 1, 2, 0, 1, 2, 0, 0, 0); cycle("rd0");
    chk("rd0.rw_const", 32'(ex_reg_write), 32'd0);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 85, ops[$urandom_range(0, 7)], fns[$urandom_range(0, 7)],
            5'($urandom), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
            5'($urandom_range(0, 9)), $urandom, $urandom, 16'($urandom),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
      if (n % 50 == 7) id_opcode = 6'h3F;
      cycle("rand");
    end

    // reset in the middle of a load-use stall
    drive(1, 6'h23, 0, 0, 1, 8, 0, 100, 0, 16'h4, 0, 0); cycle("lw4");
    drive(1, 6'h00, 6'h20, 0, 8, 2, 9, 11, 22, 0, 0, 0);
    #1;
    chk("pre_rst.stall", 32'(stall_id), 32'd1);
    reset_n = 0;
    #1;
    exp_ex = bubble();
    check_ex("mid_rst");
    chk("mid_rst.stall", 32'(stall_id), 32'd0);
    @(negedge clk); reset_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
